axi_lite_sig_master: RTL and testbench

- AXI4-Lite master sequencer that drives the signature core's AXI4-Lite register slave from a simple valid/ready job interface.
- Per job it performs five steps:
  - writes the message word;
  - writes the control register with start and op_select;
  - polls status until done, error or timeout;
  - reads the output word;
  - returns one result beat.
- Sits between the host-side command logic (or a test harness) and the register slave.

---
 rtl/axi_lite_sig_master.sv | 203 ++++++++++++++++++++
 tb/tb_axi_lite_sig_master.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_sig_master.sv
// AXI4-Lite master that runs one signature-core job per request: write message,
// write control/start, poll status, read output, return a single result beat.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// S_IDLE       | ready for a job (job_ready = 1)
// S_WR_DATA    | AW/W to data-in register (0x8)
// S_WR_DATA_B  | waiting for B of data-in write
// S_WR_CTRL    | AW/W to control register (0x0): {op, start}
// S_WR_CTRL_B  | waiting for B of control write
// S_RD_STAT    | AR to status register (0x4)
// S_RD_STAT_R  | waiting for status R beat, then decode
// S_RD_OUT     | AR to data-out register (0xC)
// S_RD_OUT_R   | waiting for data-out R beat
// S_RESULT     | result beat presented until res_ready
module axi_lite_sig_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int POLL_LIMIT = 1024,
    parameter int CNT_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [1:0]            job_op,
    input  logic [DATA_WIDTH-1:0] job_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [1:0]            res_status,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_WR_DATA   = 4'd1;
    localparam logic [3:0] S_WR_DATA_B = 4'd2;
    localparam logic [3:0] S_WR_CTRL   = 4'd3;
    localparam logic [3:0] S_WR_CTRL_B = 4'd4;
    localparam logic [3:0] S_RD_STAT   = 4'd5;
    localparam logic [3:0] S_RD_STAT_R = 4'd6;
    localparam logic [3:0] S_RD_OUT    = 4'd7;
    localparam logic [3:0] S_RD_OUT_R  = 4'd8;
    localparam logic [3:0] S_RESULT    = 4'd9;

    localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STAT = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ADDR_DIN  = ADDR_WIDTH'(8);
    localparam logic [ADDR_WIDTH-1:0] ADDR_DOUT = ADDR_WIDTH'(12);

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_CORE    = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_BUS     = 2'd3;

    logic [3:0]           state;
    logic [1:0]           op_q;
    logic [CNT_WIDTH-1:0] poll_cnt;
    logic [CNT_WIDTH-1:0] poll_nxt;
    logic                 aw_done;
    logic                 w_done;

    // Handshake/valid outputs derive from state or registered flags so that
    // reset drops them asynchronously.
    assign job_ready    = (state == S_IDLE);
    assign res_valid    = (state == S_RESULT);
    assign m_axi_bready = (state == S_WR_DATA_B) || (state == S_WR_CTRL_B);
    assign m_axi_rready = (state == S_RD_STAT_R) || (state == S_RD_OUT_R);
    assign m_axi_wstrb  = 4'hF;

    assign aw_done  = !m_axi_awvalid || m_axi_awready;
    assign w_done   = !m_axi_wvalid || m_axi_wready;
    assign poll_nxt = poll_cnt + CNT_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            op_q          <= 2'd0;
            poll_cnt      <= '0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            res_data      <= '0;
            res_status    <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (job_valid) begin
                        op_q          <= job_op;
                        m_axi_wdata   <= job_data;
                        m_axi_awaddr  <= ADDR_DIN;
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        poll_cnt      <= '0;
                        state         <= S_WR_DATA;
                    end
                end
                S_WR_DATA, S_WR_CTRL: begin
                    if (m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
                    if (aw_done && w_done)
                        state <= (state == S_WR_DATA) ? S_WR_DATA_B : S_WR_CTRL_B;
                end
                S_WR_DATA_B: begin
                    if (m_axi_bvalid) begin
                        if (m_axi_bresp != 2'b00) begin
                            res_data   <= '0;
                            res_status <= ST_BUS;
                            state      <= S_RESULT;
                        end else begin
                            m_axi_awaddr  <= ADDR_CTRL;
                            m_axi_wdata   <= DATA_WIDTH'({op_q, 1'b1});
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= S_WR_CTRL;
                        end
                    end
                end
                S_WR_CTRL_B: begin
                    if (m_axi_bvalid) begin
                        if (m_axi_bresp != 2'b00) begin
                            res_data   <= '0;
                            res_status <= ST_BUS;
                            state      <= S_RESULT;
                        end else begin
                            m_axi_araddr  <= ADDR_STAT;
                            m_axi_arvalid <= 1'b1;
                            state         <= S_RD_STAT;
                        end
                    end
                end
                S_RD_STAT, S_RD_OUT: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        state <= (state == S_RD_STAT) ? S_RD_STAT_R : S_RD_OUT_R;
                    end
                end
                S_RD_STAT_R: begin
                    if (m_axi_rvalid) begin
                        if (m_axi_rresp != 2'b00) begin
                            res_data   <= '0;
                            res_status <= ST_BUS;
                            state      <= S_RESULT;
                        end else if (m_axi_rdata[2]) begin
                            res_data   <= '0;
                            res_status <= ST_CORE;
                            state      <= S_RESULT;
                        end else if (m_axi_rdata[1] && !m_axi_rdata[0]) begin
                            m_axi_araddr  <= ADDR_DOUT;
                            m_axi_arvalid <= 1'b1;
                            state         <= S_RD_OUT;
                        end else if (poll_nxt == CNT_WIDTH'(POLL_LIMIT)) begin
                            poll_cnt   <= poll_nxt;
                            res_data   <= '0;
                            res_status <= ST_TIMEOUT;
                            state      <= S_RESULT;
                        end else begin
                            poll_cnt      <= poll_nxt;
                            m_axi_arvalid <= 1'b1;
                            state         <= S_RD_STAT;
                        end
                    end
                end
                S_RD_OUT_R: begin
                    if (m_axi_rvalid) begin
                        if (m_axi_rresp != 2'b00) begin
                            res_data   <= '0;
                            res_status <= ST_BUS;
                        end else begin
                            res_data   <= m_axi_rdata;
                            res_status <= ST_OK;
                        end
                        state <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (res_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_sig_master.sv
// Directed bench for axi_lite_sig_master: a behavioural register slave with
// configurable ready delays, responses and status sequence, plus a vector table.
module tb_axi_lite_sig_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        job_valid, job_ready;
    logic [1:0]  job_op;
    logic [31:0] job_data;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [1:0]  res_status;
    logic [3:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    axi_lite_sig_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .POLL_LIMIT(4), .CNT_WIDTH(11)) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready), .job_op(job_op), .job_data(job_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_status(res_status),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] data;
        int          aw_d;
        int          w_d;
        logic [1:0]  bresp_d;
        logic [1:0]  bresp_c;
        logic [1:0]  rresp_o;
        logic [31:0] s0;
        logic [31:0] s1;
        logic [31:0] s2;
        int          ns;
        logic [31:0] out;
        logic [1:0]  e_status;
        logic [31:0] e_data;
        int          e_b;
        int          e_stat;
        int          e_out;
        int          e_skew;
        logic [31:0] e_dword;
        logic [31:0] e_cword;
    } vec_t;

    vec_t vecs[9];

    // slave configuration
    int          cfg_aw_d, cfg_w_d, cfg_ns;
    logic [1:0]  cfg_bresp_d, cfg_bresp_c, cfg_rresp_o;
    logic [31:0] cfg_stat[3];
    logic [31:0] cfg_out;

    // slave state and per-job observations
    int          aw_wait, w_wait, stat_idx;
    logic        aw_got, w_got, rd_pend;
    logic [3:0]  wr_addr, rd_addr;
    logic [31:0] wr_word;
    int          n_b, n_stat_rd, n_out_rd, n_overlap, n_skew;
    logic [31:0] log_dword, log_cword;

    int n_checks = 0;
    int n_err = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            aw_got  = 1'b0;
            w_got   = 1'b0;
            rd_pend = 1'b0;
        end else begin
            if ((awvalid || wvalid || bready) && (arvalid || rready)) n_overlap++;
            if (awvalid && !wvalid) n_skew++;
            if (awvalid && awready) begin aw_got = 1'b1; wr_addr = awaddr; end
            if (wvalid && wready)   begin w_got = 1'b1; wr_word = wdata; end
            if (bvalid && bready) begin
                n_b++;
                if (wr_addr == 4'd8) log_dword = wr_word;
                else if (wr_addr == 4'd0) log_cword = wr_word;
                aw_got = 1'b0;
                w_got  = 1'b0;
            end
            if (arvalid && arready) begin
                rd_pend = 1'b1;
                rd_addr = araddr;
                if (araddr == 4'd4) n_stat_rd++;
                else if (araddr == 4'd12) n_out_rd++;
            end
            if (rvalid && rready) begin
                rd_pend = 1'b0;
                if (rd_addr == 4'd4) stat_idx++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
            aw_wait = 0; w_wait = 0;
        end else begin
            if (awvalid) begin awready = (aw_wait >= cfg_aw_d); aw_wait++; end
            else begin awready = 1'b0; aw_wait = 0; end
            if (wvalid) begin wready = (w_wait >= cfg_w_d); w_wait++; end
            else begin wready = 1'b0; w_wait = 0; end
            bvalid  = aw_got && w_got;
            bresp   = (wr_addr == 4'd8) ? cfg_bresp_d : cfg_bresp_c;
            arready = arvalid;
            rvalid  = rd_pend;
            if (rd_addr == 4'd4) begin
                rdata = cfg_stat[(stat_idx < cfg_ns) ? stat_idx : cfg_ns - 1];
                rresp = 2'b00;
            end else begin
                rdata = cfg_out;
                rresp = cfg_rresp_o;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic setup(input vec_t v);
        cfg_aw_d = v.aw_d; cfg_w_d = v.w_d; cfg_ns = v.ns;
        cfg_bresp_d = v.bresp_d; cfg_bresp_c = v.bresp_c; cfg_rresp_o = v.rresp_o;
        cfg_stat[0] = v.s0; cfg_stat[1] = v.s1; cfg_stat[2] = v.s2;
        cfg_out = v.out;
        stat_idx = 0; n_b = 0; n_stat_rd = 0; n_out_rd = 0; n_overlap = 0; n_skew = 0;
        log_dword = 32'hFFFF_FFFF; log_cword = 32'hFFFF_FFFF;
    endtask

    task automatic start_job(input vec_t v);
        int t;
        t = 0;
        while (!job_ready && t < 20) begin @(negedge clk); t++; end
        chk("job_ready_before_start", {31'd0, job_ready}, 32'd1);
        job_op = v.op; job_data = v.data; job_valid = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic wait_result(output bit ok);
        int t;
        t = 0;
        while (!res_valid && t < 500) begin @(negedge clk); t++; end
        ok = res_valid;
        if (!ok) begin
            n_checks++; n_err++;
            $display("FAIL result_timeout: res_valid never rose within %0d cycles", t);
        end
    endtask

    task automatic finish_job(input vec_t v, input int idx);
        string p;
        p = $sformatf("v%0d", idx);
        chk({p, "_res_status"}, {30'd0, res_status}, {30'd0, v.e_status});
        chk({p, "_res_data"}, res_data, v.e_data);
        chk({p, "_job_ready_busy"}, {31'd0, job_ready}, 32'd0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({p, "_res_valid_drop"}, {31'd0, res_valid}, 32'd0);
        chk({p, "_job_ready_after"}, {31'd0, job_ready}, 32'd1);
        chk({p, "_b_count"}, 32'(n_b), 32'(v.e_b));
        chk({p, "_stat_reads"}, 32'(n_stat_rd), 32'(v.e_stat));
        chk({p, "_out_reads"}, 32'(n_out_rd), 32'(v.e_out));
        chk({p, "_skew_cycles"}, 32'(n_skew), 32'(v.e_skew));
        chk({p, "_data_word"}, log_dword, v.e_dword);
        chk({p, "_ctrl_word"}, log_cword, v.e_cword);
        chk({p, "_rw_overlap"}, 32'(n_overlap), 32'd0);
    endtask

    initial begin
        bit ok;
        //          op     data          awd wd bd     bc     ro     s0     s1     s2     ns out            est    edata         eb est eo skw edword        ecword
        vecs[0] = '{2'd0, 32'h12345678, 0, 0, 2'd0, 2'd0, 2'd0, 32'd1, 32'd1, 32'd2, 3, 32'hCAFEF00D, 2'd0, 32'hCAFEF00D, 2, 3, 1, 0, 32'h12345678, 32'h1};
        vecs[1] = '{2'd1, 32'hA5A50001, 3, 0, 2'd0, 2'd0, 2'd0, 32'd2, 32'd2, 32'd2, 1, 32'h11112222, 2'd0, 32'h11112222, 2, 1, 1, 6, 32'hA5A50001, 32'h3};
        vecs[2] = '{2'd2, 32'hDEAD0002, 0, 0, 2'd0, 2'd0, 2'd0, 32'd7, 32'd7, 32'd7, 1, 32'h55555555, 2'd1, 32'h0,         2, 1, 0, 0, 32'hDEAD0002, 32'h5};
        vecs[3] = '{2'd0, 32'h00000004, 0, 0, 2'd0, 2'd0, 2'd0, 32'd1, 32'd1, 32'd1, 1, 32'h55555555, 2'd2, 32'h0,         2, 4, 0, 0, 32'h4,        32'h1};
        vecs[4] = '{2'd3, 32'h00000005, 0, 0, 2'd0, 2'd2, 2'd0, 32'd2, 32'd2, 32'd2, 1, 32'h55555555, 2'd3, 32'h0,         2, 0, 0, 0, 32'h5,        32'h7};
        vecs[5] = '{2'd0, 32'h00000006, 0, 0, 2'd0, 2'd0, 2'd2, 32'd2, 32'd2, 32'd2, 1, 32'h99999999, 2'd3, 32'h0,         2, 1, 1, 0, 32'h6,        32'h1};
        vecs[6] = '{2'd1, 32'h00000007, 0, 0, 2'd2, 2'd0, 2'd0, 32'd2, 32'd2, 32'd2, 1, 32'h55555555, 2'd3, 32'h0,         1, 0, 0, 0, 32'h7,        32'hFFFFFFFF};
        vecs[7] = '{2'd2, 32'h00000008, 0, 2, 2'd0, 2'd0, 2'd0, 32'd3, 32'd3, 32'd2, 3, 32'h77778888, 2'd0, 32'h77778888, 2, 3, 1, 0, 32'h8,        32'h5};
        vecs[8] = '{2'd0, 32'h00000009, 0, 0, 2'd0, 2'd0, 2'd0, 32'd6, 32'd6, 32'd6, 1, 32'h55555555, 2'd1, 32'h0,         2, 1, 0, 0, 32'h9,        32'h1};

        rst_n = 1'b0; job_valid = 1'b0; job_op = 2'd0; job_data = 32'd0; res_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00;
        rd_addr = 4'd0; wr_addr = 4'd0; wr_word = 32'd0;
        setup(vecs[0]);
        repeat (3) @(negedge clk);
        chk("reset_job_ready", {31'd0, job_ready}, 32'd1);
        chk("reset_valids", {26'd0, awvalid, wvalid, arvalid, bready, rready, res_valid}, 32'd0);
        chk("reset_wstrb", {28'd0, wstrb}, 32'hF);
        chk("reset_res", {res_data[29:0], res_status}, 32'd0);
        chk("reset_addr", {24'd0, awaddr, araddr}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            setup(vecs[i]);
            start_job(vecs[i]);
            wait_result(ok);
            if (ok) finish_job(vecs[i], i);
        end

        // result back-pressure: outputs hold while res_ready is low
        setup(vecs[0]);
        start_job(vecs[0]);
        wait_result(ok);
        if (ok) begin
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                chk("bp_res_valid", {31'd0, res_valid}, 32'd1);
                chk("bp_res_data", res_data, 32'hCAFEF00D);
                chk("bp_job_ready", {31'd0, job_ready}, 32'd0);
            end
            finish_job(vecs[0], 100);
        end

        // reset while a write address is pending
        setup(vecs[0]);
        cfg_aw_d = 20; cfg_w_d = 20;
        start_job(vecs[0]);
        begin
            int t;
            t = 0;
            while (!awvalid && t < 10) begin @(negedge clk); t++; end
        end
        chk("rst_mid_awvalid_before", {31'd0, awvalid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_awvalid", {31'd0, awvalid}, 32'd0);
        chk("rst_mid_wvalid", {31'd0, wvalid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_job_ready", {31'd0, job_ready}, 32'd1);

        // recovery job after reset
        setup(vecs[0]);
        start_job(vecs[0]);
        wait_result(ok);
        if (ok) finish_job(vecs[0], 200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
